mem_response: RTL and testbench

- Pipeline stage between memory_b and writeback.
- Takes each memory_b slot and, for loads, waits for the data memory read response. The wait is variable latency, bounded by a timeout.
- Aligns and extends load data, then raises alignment and bus faults as live exception slots.
- Stalls upstream while a load is pending. Discards responses that belong to squashed loads.

---
 rtl/mem_response_pkg.sv | 52 +++++
 rtl/mem_response_if.sv | 37 +++
 rtl/mem_response_load_align.sv | 26 ++
 rtl/mem_response.sv | 132 +++++++++++++
 tb/tb_mem_response.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_response_pkg.sv
// Shared definitions for the memory-response pipeline stage: exception codes,
// the load-size encoding, FSM states and the slot records moved between stages.
package mem_response_pkg;

  localparam logic [7:0] ExcAlign = 8'h84;
  localparam logic [7:0] ExcBus   = 8'h85;

  typedef enum logic [1:0] {
    SizeByte = 2'd0,
    SizeHalf = 2'd1,
    SizeWord = 2'd2
  } load_size_e;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDrain
  } state_e;

  // Load held while its read response is outstanding.
  typedef struct packed {
    logic [4:0]  opcode;
    logic [4:0]  tgt;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [1:0]  size;
    logic        sign_ext;
  } load_slot_t;

  // Registered slot presented to writeback.
  typedef struct packed {
    logic        bubble;
    logic [4:0]  opcode;
    logic [4:0]  tgt;
    logic [31:0] result;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [7:0]  exc;
  } wb_slot_t;

  // Size code 3 is treated like a word access.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] addr);
    logic mis;
    case (size)
      SizeByte: mis = 1'b0;
      SizeHalf: mis = addr[0];
      default:  mis = (addr != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_response_if.sv
// Slot, data-memory response and writeback signals of the memory-response stage.
interface mem_response_if;
  logic        bubble_in;
  logic [4:0]  opcode_in;
  logic [4:0]  tgt_in_1;
  logic [31:0] result_in_1;
  logic [31:0] addr_in;
  logic [31:0] pc_in;
  logic [7:0]  exc_in;
  logic        is_load;
  logic [1:0]  load_size;
  logic        load_signed;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        stall_out;
  logic        bubble_out;
  logic [4:0]  opcode_out;
  logic [4:0]  tgt_out_1;
  logic [31:0] result_out_1;
  logic [31:0] addr_out;
  logic [31:0] pc_out;
  logic [7:0]  exc_out;

  // Upstream stage / memory side.
  modport master (
    output bubble_in, opcode_in, tgt_in_1, result_in_1, addr_in, pc_in, exc_in,
    output is_load, load_size, load_signed, mem_rdata, mem_rvalid,
    input  stall_out, bubble_out, opcode_out, tgt_out_1, result_out_1, addr_out, pc_out, exc_out
  );

  // The stage itself.
  modport slave (
    input  bubble_in, opcode_in, tgt_in_1, result_in_1, addr_in, pc_in, exc_in,
    input  is_load, load_size, load_signed, mem_rdata, mem_rvalid,
    output stall_out, bubble_out, opcode_out, tgt_out_1, result_out_1, addr_out, pc_out, exc_out
  );
endinterface

// File: rtl/mem_response_load_align.sv
// Selects the addressed byte/half/word from a little-endian read word and extends it.
module mem_response_load_align
  import mem_response_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by zero/sign extension.
  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SizeByte: data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SizeHalf: data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_response.sv
// Memory-response stage: waits for load data with a timeout, aligns it, raises
// alignment/bus faults, and discards responses belonging to squashed loads.
module mem_response
  import mem_response_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 64,
  parameter logic [7:0]  EXC_ALIGN = ExcAlign,
  parameter logic [7:0]  EXC_BUS   = ExcBus
) (
  input logic           clk,
  input logic           rst,
  input logic           clk_en,
  input logic           halt,
  input logic           exc_in_wb,
  input logic           rfe_in_wb,
  mem_response_if.slave bus
);

  localparam int unsigned     CntW     = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax   = CntW'(TIMEOUT);
  localparam wb_slot_t        WbBubble = '{bubble: 1'b1, default: '0};

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  load_slot_t      lat_q, lat_d;
  wb_slot_t        out_q, out_d;

  logic        squash;
  logic        slot_load;
  logic        slot_misaligned;
  logic        drain_block;
  logic        in_wait;
  logic [31:0] aligned_data;

  assign in_wait         = (state_q == StWait);
  assign squash          = exc_in_wb | rfe_in_wb | halt;
  assign slot_load       = !bus.bubble_in && (bus.exc_in == '0) && bus.is_load;
  assign slot_misaligned = is_misaligned(bus.load_size, bus.addr_in[1:0]);
  // A new aligned load in DRAIN would consume the stale response, so hold it back.
  assign drain_block     = (state_q == StDrain) && slot_load && !slot_misaligned;

  // One aligner serves both the waiting load and a same-cycle incoming response.
  mem_response_load_align u_load_align (
    .rdata    (bus.mem_rdata),
    .addr     (in_wait ? lat_q.addr[1:0] : bus.addr_in[1:0]),
    .size     (in_wait ? lat_q.size : bus.load_size),
    .sign_ext (in_wait ? lat_q.sign_ext : bus.load_signed),
    .data     (aligned_data)
  );

  // Next-state, counter and writeback-slot selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    out_d     = WbBubble;
    out_d.pc  = in_wait ? lat_q.pc : bus.pc_in;
    if (squash) begin
      // A response arriving with the squash is the one we would otherwise drain.
      state_d = (in_wait && !bus.mem_rvalid) ? StDrain : StIdle;
      cnt_d   = '0;
    end else if (in_wait) begin
      if (bus.mem_rvalid || (cnt_q == CntMax)) begin
        out_d.bubble = 1'b0;
        out_d.opcode = lat_q.opcode;
        out_d.tgt    = lat_q.tgt;
        out_d.addr   = lat_q.addr;
        cnt_d        = '0;
        if (bus.mem_rvalid) begin
          out_d.result = aligned_data;
          state_d      = StIdle;
        end else begin
          out_d.exc = EXC_BUS;
          state_d   = StDrain;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (drain_block) begin
      if (bus.mem_rvalid) state_d = StIdle;
    end else begin
      if ((state_q == StDrain) && bus.mem_rvalid) state_d = StIdle;
      if (!bus.bubble_in) begin
        out_d.bubble = 1'b0;
        out_d.opcode = bus.opcode_in;
        out_d.tgt    = bus.tgt_in_1;
        out_d.result = bus.result_in_1;
        out_d.addr   = bus.addr_in;
        out_d.exc    = bus.exc_in;
        if (slot_load) begin
          if (slot_misaligned) begin
            out_d.exc = EXC_ALIGN;
          end else if (bus.mem_rvalid) begin
            out_d.result = aligned_data;
          end else begin
            out_d    = WbBubble;
            out_d.pc = bus.pc_in;
            lat_d    = '{opcode: bus.opcode_in, tgt: bus.tgt_in_1, addr: bus.addr_in,
                         pc: bus.pc_in, size: bus.load_size, sign_ext: bus.load_signed};
            state_d  = StWait;
            cnt_d    = CntW'(1);
          end
        end
      end
    end
  end

  // State, timeout counter, latched load and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lat_q   <= '0;
      out_q   <= WbBubble;
    end else if (clk_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      out_q   <= out_d;
    end
  end

  assign bus.stall_out    = in_wait | drain_block;
  assign bus.bubble_out   = out_q.bubble;
  assign bus.opcode_out   = out_q.opcode;
  assign bus.tgt_out_1    = out_q.tgt;
  assign bus.result_out_1 = out_q.result;
  assign bus.addr_out     = out_q.addr;
  assign bus.pc_out       = out_q.pc;
  assign bus.exc_out      = out_q.exc;

endmodule

// File: tb/tb_mem_response.sv
// Directed bench for mem_response with a short timeout.
module tb_mem_response;

  logic clk = 1'b0;
  logic rst, clk_en, halt, exc_in_wb, rfe_in_wb;
  int   total = 0;
  int   bad   = 0;

  mem_response_if bus ();

  mem_response #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .halt      (halt),
    .exc_in_wb (exc_in_wb),
    .rfe_in_wb (rfe_in_wb),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.bubble_in   = 1'b1;
    bus.opcode_in   = '0;
    bus.tgt_in_1    = '0;
    bus.result_in_1 = '0;
    bus.addr_in     = '0;
    bus.pc_in       = '0;
    bus.exc_in      = '0;
    bus.is_load     = 1'b0;
    bus.load_size   = '0;
    bus.load_signed = 1'b0;
    bus.mem_rdata   = '0;
    bus.mem_rvalid  = 1'b0;
  endtask

  task automatic slot(input logic [4:0] op, input logic [4:0] tgt, input logic [31:0] res,
                      input logic [31:0] addr, input logic [31:0] pc, input logic ld,
                      input logic [1:0] sz, input logic sg);
    bus.bubble_in   = 1'b0;
    bus.opcode_in   = op;
    bus.tgt_in_1    = tgt;
    bus.result_in_1 = res;
    bus.addr_in     = addr;
    bus.pc_in       = pc;
    bus.exc_in      = '0;
    bus.is_load     = ld;
    bus.load_size   = sz;
    bus.load_signed = sg;
  endtask

  initial begin
    idle_in();
    rst = 1'b1; clk_en = 1'b1; halt = 1'b0; exc_in_wb = 1'b0; rfe_in_wb = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_bubble", 32'(bus.bubble_out), 32'd1);
    chk("rst_stall", 32'(bus.stall_out), 32'd0);
    chk("rst_result", bus.result_out_1, 32'd0);
    chk("rst_pc", bus.pc_out, 32'd0);
    chk("rst_exc", 32'(bus.exc_out), 32'd0);

    // ALU slot passes through.
    slot(5'h03, 5'd7, 32'hDEADBEEF, 32'h100, 32'h1000, 1'b0, 2'd0, 1'b0);
    #1 chk("alu_stall", 32'(bus.stall_out), 32'd0);
    tick();
    chk("alu_bubble", 32'(bus.bubble_out), 32'd0);
    chk("alu_result", bus.result_out_1, 32'hDEADBEEF);
    chk("alu_tgt", 32'(bus.tgt_out_1), 32'd7);
    chk("alu_pc", bus.pc_out, 32'h1000);

    // Slot carrying an earlier exception.
    slot(5'h04, 5'd2, 32'h0, 32'h140, 32'h1400, 1'b1, 2'd2, 1'b0);
    bus.exc_in = 8'h21;
    tick();
    chk("excin_exc", 32'(bus.exc_out), 32'h21);
    chk("excin_bubble", 32'(bus.bubble_out), 32'd0);

    // Signed byte load at offset 2, response three cycles late.
    slot(5'h10, 5'd3, 32'h0, 32'h202, 32'h2000, 1'b1, 2'd0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1280_3456;
      end
      #1 chk("lb_stall", 32'(bus.stall_out), 32'd1);
      chk("lb_wait_bubble", 32'(bus.bubble_out), 32'd1);
      tick();
    end
    idle_in();
    chk("lb_result", bus.result_out_1, 32'hFFFFFF80);
    chk("lb_bubble", 32'(bus.bubble_out), 32'd0);
    chk("lb_pc", bus.pc_out, 32'h2000);
    #1 chk("lb_stall_done", 32'(bus.stall_out), 32'd0);

    // Misaligned half load.
    slot(5'h11, 5'd4, 32'h0, 32'h301, 32'h3000, 1'b1, 2'd1, 1'b0);
    #1 chk("mis_stall", 32'(bus.stall_out), 32'd0);
    tick();
    chk("mis_exc", 32'(bus.exc_out), 32'h84);
    chk("mis_addr", bus.addr_out, 32'h301);
    chk("mis_bubble", 32'(bus.bubble_out), 32'd0);
    idle_in();
    tick();
    chk("mis_after_stall", 32'(bus.stall_out), 32'd0);
    chk("mis_after_addr", bus.addr_out, 32'd0);

    // Word load that times out after four wait cycles.
    slot(5'h12, 5'd5, 32'h0, 32'h400, 32'h4000, 1'b1, 2'd2, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_stall", 32'(bus.stall_out), 32'd1);
      tick();
    end
    idle_in();
    chk("to_exc", 32'(bus.exc_out), 32'h85);
    chk("to_bubble", 32'(bus.bubble_out), 32'd0);
    chk("to_result", bus.result_out_1, 32'd0);
    chk("to_addr", bus.addr_out, 32'h400);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hAAAA_AAAA;
    #1 chk("to_drain_stall", 32'(bus.stall_out), 32'd0);
    tick();
    chk("to_drop_bubble", 32'(bus.bubble_out), 32'd1);
    chk("to_drop_result", bus.result_out_1, 32'd0);
    idle_in();
    slot(5'h03, 5'd9, 32'h1234_5678, 32'h440, 32'h4400, 1'b0, 2'd0, 1'b0);
    tick();
    chk("to_alu_result", bus.result_out_1, 32'h1234_5678);
    chk("to_alu_exc", 32'(bus.exc_out), 32'd0);
    chk("to_alu_bubble", 32'(bus.bubble_out), 32'd0);

    // Squash during WAIT, then a new load must wait for the stale response to drain.
    slot(5'h12, 5'd6, 32'h0, 32'h500, 32'h5000, 1'b1, 2'd2, 1'b0);
    tick();
    chk("sq_wait_stall", 32'(bus.stall_out), 32'd1);
    exc_in_wb = 1'b1;
    tick();
    exc_in_wb = 1'b0;
    chk("sq_bubble", 32'(bus.bubble_out), 32'd1);
    chk("sq_exc", 32'(bus.exc_out), 32'd0);
    chk("sq_tgt", 32'(bus.tgt_out_1), 32'd0);
    slot(5'h12, 5'd8, 32'h0, 32'h600, 32'h6000, 1'b1, 2'd2, 1'b0);
    #1 chk("sq_drain_stall", 32'(bus.stall_out), 32'd1);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0000_0055;
    #1 chk("sq_stale_stall", 32'(bus.stall_out), 32'd1);
    tick();
    bus.mem_rvalid = 1'b0;
    chk("sq_stale_bubble", 32'(bus.bubble_out), 32'd1);
    chk("sq_stale_result", bus.result_out_1, 32'd0);
    #1 chk("sq_idle_stall", 32'(bus.stall_out), 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    tick();
    idle_in();
    chk("sq_new_result", bus.result_out_1, 32'hCAFE_F00D);
    chk("sq_new_bubble", 32'(bus.bubble_out), 32'd0);

    // Same-cycle unsigned half load from the upper lane.
    slot(5'h11, 5'd10, 32'h0, 32'h702, 32'h7000, 1'b1, 2'd1, 1'b0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h8001_0000;
    tick();
    idle_in();
    chk("lhu_result", bus.result_out_1, 32'h0000_8001);

    // Reset during WAIT, then a normal word load with clk_en gaps.
    slot(5'h12, 5'd11, 32'h0, 32'h740, 32'h7400, 1'b1, 2'd2, 1'b0);
    tick();
    idle_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_bubble", 32'(bus.bubble_out), 32'd1);
    chk("rw_stall", 32'(bus.stall_out), 32'd0);
    chk("rw_pc", bus.pc_out, 32'd0);
    chk("rw_addr", bus.addr_out, 32'd0);
    slot(5'h12, 5'd12, 32'h0, 32'h800, 32'h8000, 1'b1, 2'd2, 1'b0);
    tick();
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    clk_en = 1'b1;
    chk("ce_stall", 32'(bus.stall_out), 32'd1);
    chk("ce_bubble", 32'(bus.bubble_out), 32'd1);
    tick();
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1122_3344;
    tick();
    idle_in();
    chk("rw_result", bus.result_out_1, 32'h1122_3344);
    chk("rw_exc", 32'(bus.exc_out), 32'd0);
    chk("rw_res_bubble", 32'(bus.bubble_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
